mem_access_unit: RTL and testbench

Load/store front-end between the CPU's MEM pipeline stage and the word-addressed data RAM. Accepts byte, halfword and word loads and stores, and drives the RAM's word-only port. Sub-word stores are done as read-modify-write. Returns sign- or zero-extended load data and a completion pulse, and holds off the pipeline while an access is in flight.

---
 rtl/mips_mem_pkg.sv | 40 ++++
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/mem_access_unit.sv | 138 +++++++++++++
 tb/tb_mem_access_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store front-end: access sizes, FSM states and
// the request fields held for the duration of an access.
package mips_mem_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOAD,
        RMW_READ,
        STORE,
        RESP
    } state_t;

    // Request fields kept after accept; the word address lives in ram_address.
    typedef struct packed {
        logic [1:0]        size;
        logic              is_unsigned;
        logic [1:0]        lane;
        logic [DATA_W-1:0] wdata;
    } req_lat_t;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; size 11 behaves as word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = lo[0];
            default:   mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bundle of the load/store front-end.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends load data, and merges
// store data into a read word for sub-word read-modify-write.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data_c,
    output logic [DATA_W-1:0] merge_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_b;
    logic        sign_h;

    always_comb begin
        byte_sel = rdata[7:0];
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Halfword lane ignores addr[0], so misaligned halves read the aligned one.
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        sign_b   = ~is_unsigned & byte_sel[7];
        sign_h   = ~is_unsigned & half_sel[15];
    end

    always_comb begin
        load_data_c  = rdata;
        merge_data_c = wdata;
        case (size)
            SIZE_BYTE: begin
                load_data_c = {{24{sign_b}}, byte_sel};
                case (lane)
                    2'd0:    merge_data_c = {rdata[31:8], wdata[7:0]};
                    2'd1:    merge_data_c = {rdata[31:16], wdata[7:0], rdata[7:0]};
                    2'd2:    merge_data_c = {rdata[31:24], wdata[7:0], rdata[15:0]};
                    default: merge_data_c = {wdata[7:0], rdata[23:0]};
                endcase
            end
            SIZE_HALF: begin
                load_data_c  = {{16{sign_h}}, half_sel};
                merge_data_c = lane[1] ? {wdata[15:0], rdata[15:0]}
                                       : {rdata[31:16], wdata[15:0]};
            end
            default: begin
                load_data_c  = rdata;
                merge_data_c = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end between the MEM stage and a word-only data RAM.
// Optional misalignment trapping is built when MEM_ACCESS_MISALIGN_CHECK_EN is defined.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_access_unit_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_write,
    output logic                  ram_write_en,
    output logic                  ram_read_en,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    state_t                state_q, state_d;
    req_lat_t              lat_q, lat_d;
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_error_q, resp_error_d;
    logic [ADDR_WIDTH-1:0] ram_address_d;
    logic [DATA_WIDTH-1:0] ram_data_write_d;
    logic                  ram_write_en_d;
    logic                  ram_read_en_d;
    logic                  accept;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] load_data_c;
    logic [DATA_WIDTH-1:0] merge_data_c;

    mem_lane_align u_align (
        .size         (lat_q.size),
        .is_unsigned  (lat_q.is_unsigned),
        .lane         (lat_q.lane),
        .rdata        (ram_data_out),
        .wdata        (lat_q.wdata),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    assign accept = bus.req_valid && ready_q;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // Next state plus next values of every registered output.
    always_comb begin
        state_d          = state_q;
        lat_d            = lat_q;
        resp_rdata_d     = resp_rdata_q;
        resp_error_d     = resp_error_q;
        ram_address_d    = ram_address;
        ram_data_write_d = ram_data_write;

        case (state_q)
            INIT: state_d = IDLE;
            IDLE: begin
                if (accept) begin
                    lat_d.size        = bus.req_size;
                    lat_d.is_unsigned = bus.req_unsigned;
                    lat_d.lane        = bus.req_addr[1:0];
                    lat_d.wdata       = bus.req_wdata;
                    ram_address_d     = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                    resp_error_d      = misaligned;
                    if (misaligned) begin
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end else if (!bus.req_write) begin
                        state_d = LOAD;
                    end else if (bus.req_size == SIZE_BYTE || bus.req_size == SIZE_HALF) begin
                        state_d = RMW_READ;
                    end else begin
                        ram_data_write_d = bus.req_wdata;
                        state_d          = STORE;
                    end
                end
            end
            LOAD: begin
                resp_rdata_d = load_data_c;
                state_d      = RESP;
            end
            RMW_READ: begin
                ram_data_write_d = merge_data_c;
                state_d          = STORE;
            end
            STORE: begin
                resp_rdata_d = '0;
                state_d      = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = INIT;
        endcase

        // Moore outputs are registered from the state being entered.
        ready_d        = (state_d == IDLE);
        resp_valid_d   = (state_d == RESP);
        ram_read_en_d  = (state_d == LOAD) || (state_d == RMW_READ);
        ram_write_en_d = (state_d == STORE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= INIT;
            lat_q          <= '0;
            ready_q        <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_error_q   <= 1'b0;
            ram_address    <= '0;
            ram_data_write <= '0;
            ram_write_en   <= 1'b0;
            ram_read_en    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lat_q          <= lat_d;
            ready_q        <= ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_error_q   <= resp_error_d;
            ram_address    <= ram_address_d;
            ram_data_write <= ram_data_write_d;
            ram_write_en   <= ram_write_en_d;
            ram_read_en    <= ram_read_en_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word RAM model and a response scoreboard.
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] ram_address;
    logic [31:0] ram_data_write;
    logic        ram_write_en;
    logic        ram_read_en;
    logic [31:0] ram_data_out;
    logic [31:0] mem [0:63];

    exp_t  sb_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    resp_count = 0;
    int    last_resp_cyc = 0;
    int    we_count = 0;
    int    we_cyc = 0;
    int    re_count = 0;
    int    acc_cyc = 0;
    string cur_tag = "none";

    mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .ram_address    (ram_address),
        .ram_data_write (ram_data_write),
        .ram_write_en   (ram_write_en),
        .ram_read_en    (ram_read_en),
        .ram_data_out   (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ram_data_out = mem[ram_address[7:2]];
    always @(posedge clk) if (ram_write_en) mem[ram_address[7:2]] <= ram_data_write;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (ram_write_en) begin we_count++; we_cyc = cyc; end
        if (ram_read_en) re_count++;
        if (bus.resp_valid) begin
            resp_count++;
            last_resp_cyc = cyc;
            if (sb_q.size() == 0) begin
                chk({cur_tag, "_unexpected_resp"}, 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk({cur_tag, "_rdata"}, bus.resp_rdata, e.rdata);
                chk({cur_tag, "_error"}, 32'(bus.resp_error), 32'(e.err));
                chk({cur_tag, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic access(input string tag, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int lat);
        exp_t e;
        int   n;
        int   r0;
        logic ready_bad;
        cur_tag          = tag;
        we_count         = 0;
        re_count         = 0;
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_accept"}, 32'(bus.req_ready), 32'd1);
        acc_cyc = cyc;
        e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.acc = cyc;
        sb_q.push_back(e);
        r0 = resp_count;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        ready_bad = 1'b0;
        n = 0;
        while (resp_count == r0 && n < 10) begin
            @(negedge clk); #1; n++;
            if (bus.req_ready !== 1'b0) ready_bad = 1'b1;
        end
        chk({tag, "_resp_seen"}, 32'(resp_count - r0), 32'd1);
        chk({tag, "_ready_busy"}, 32'(ready_bad), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h876543F1;
        mem[5] = 32'h00000000;
        mem[6] = 32'hCAFEF00D;
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
        chk("rst_ram_we", 32'(ram_write_en), 32'd0);
        chk("rst_ram_re", 32'(ram_read_en), 32'd0);
        chk("rst_ram_addr", ram_address, 32'h0);
        chk("rst_ram_wdata", ram_data_write, 32'h0);

        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("init_ready_low", 32'(bus.req_ready), 32'd0);
        @(negedge clk); #1;
        chk("idle_ready_high", 32'(bus.req_ready), 32'd1);

        access("lb_13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF87, 1'b0, 2);
        access("lbu_10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h000000F1, 1'b0, 2);
        access("lh_12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8765, 1'b0, 2);
        access("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h000043F1, 1'b0, 2);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        access("lh_11_mis", 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1, 1);
        chk("lh_11_no_read", 32'(re_count), 32'd0);
        chk("lh_11_no_write", 32'(we_count), 32'd0);
`else
        access("lh_11_mis", 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 32'h000043F1, 1'b0, 2);
        chk("lh_11_one_read", 32'(re_count), 32'd1);
`endif

        access("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 32'h0, 1'b0, 3);
        chk("sb_11_we_count", 32'(we_count), 32'd1);
        chk("sb_11_we_cycle", 32'(we_cyc - acc_cyc), 32'd2);
        chk("sb_11_mem", mem[4], 32'h8765AAF1);

        access("sw_14", 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        chk("sw_14_we_count", 32'(we_count), 32'd1);
        chk("sw_14_we_cycle", 32'(we_cyc - acc_cyc), 32'd1);
        n = last_resp_cyc;
        access("lw_14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        chk("lw_14_back_to_back", 32'(acc_cyc), 32'(n + 1));

        access("sh_16", 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234, 32'h0, 1'b0, 3);
        chk("sh_16_mem", mem[5], 32'h1234BEEF);
        access("lh_16",  1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 32'h00001234, 1'b0, 2);
        access("lb_15",  1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 32'hFFFFFFBE, 1'b0, 2);
        access("lb_17",  1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 32'h00000012, 1'b0, 2);
        access("lw_sz11", 1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 32'h1234BEEF, 1'b0, 2);

        // Abandon a word store with reset while it is in STORE.
        cur_tag = "sw_18_rst";
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h18; bus.req_wdata = 32'h12345678;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("sw_18_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("sw_18_in_store", 32'(ram_write_en), 32'd1);
        reset = 1'b0;
        #1;
        chk("sw_18_rst_we", 32'(ram_write_en), 32'd0);
        chk("sw_18_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("sw_18_rst_resp", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rel_init_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk); #1;
        chk("rel_idle_ready", 32'(bus.req_ready), 32'd1);
        chk("sw_18_mem_kept", mem[6], 32'hCAFEF00D);

        access("lbu_18", 1'b0, 2'b00, 1'b1, 32'h18, 32'h0, 32'h0000000D, 1'b0, 2);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
